// File: rtl/scpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scpu_pkg
// Description : Shared types and constants for the single-cycle CPU front end.
// Revision    : 1.0 - initial release
// ============================================================================
package scpu_pkg;

    localparam int unsigned      INSN_W   = 32;
    localparam logic [INSN_W-1:0] NOP_INSN = 32'h0000_0000;
    localparam int unsigned      PC_STEP  = 4;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage : scpu_pkg
`default_nettype wire

// File: rtl/scpu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : scpu_fetch
// Description : Instruction fetch stage - PC, single-outstanding imem fetch,
//               instruction register with valid/ready hand-off and redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module scpu_fetch
    import scpu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [INSN_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [INSN_W-1:0] iReg,
    output logic [ADDR_W-1:0] ir_pc
);

    fetch_state_t      r_state;
    fetch_state_t      w_stateNext;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pcNext;
    logic [ADDR_W-1:0] w_redirPc;
    logic              r_irValid;
    logic [INSN_W-1:0] r_iReg;
    logic [ADDR_W-1:0] r_irPc;
    logic              w_slotFree;
    logic              w_reqFire;
    logic              w_rspTake;

    // A request is only issued when the IR can absorb its response.
    assign w_slotFree     = !r_irValid || ir_ready;
    assign imem_req_valid = rst_n && (r_state == REQ) && w_slotFree;
    assign w_reqFire      = imem_req_valid && imem_req_ready;
    assign w_rspTake      = (r_state == WAIT) && imem_rsp_valid && !redirect_valid;
    assign w_redirPc      = redirect_pc & ~ADDR_W'(3);

    assign imem_req_addr  = r_pc;
    assign ir_valid       = r_irValid;
    assign iReg           = r_iReg;
    assign ir_pc          = r_irPc;

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            REQ: begin
                if (w_reqFire) begin
                    w_stateNext = redirect_valid ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    w_stateNext = REQ;
                end else if (redirect_valid) begin
                    w_stateNext = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_rsp_valid) begin
                    w_stateNext = REQ;
                end
            end
            default: w_stateNext = REQ;
        endcase
    end

    always_comb begin
        w_pcNext = r_pc;
        if (redirect_valid) begin
            w_pcNext = w_redirPc;
        end else if (w_rspTake) begin
            w_pcNext = r_pc + ADDR_W'(PC_STEP);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= REQ;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_stateNext;
            r_pc    <= w_pcNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irValid <= 1'b0;
            r_iReg    <= NOP_INSN;
            r_irPc    <= '0;
        end else begin
            if (redirect_valid) begin
                r_irValid <= 1'b0;
            end else if (w_rspTake) begin
                r_irValid <= 1'b1;
            end else if (r_irValid && ir_ready) begin
                r_irValid <= 1'b0;
            end
            if (w_rspTake) begin
                r_iReg <= imem_rsp_data;
                r_irPc <= r_pc;
            end
        end
    end

endmodule : scpu_fetch
`default_nettype wire

// File: tb/tb_scpu_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_scpu_fetch
// Description : Self-checking bench for scpu_fetch with an imem responder and
//               a program-order reference model of delivered instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scpu_fetch;
    import scpu_pkg::*;

    localparam int unsigned ADDR_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] SEQ_WORDS [4] = '{32'h0000_0000, 32'h0014_0082,
                                              32'h000A_0102, 32'h0004_1181};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic [31:0] iReg;
    logic [31:0] ir_pc;

    scpu_fetch #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .iReg(iReg), .ir_pc(ir_pc)
    );

    always #5 clk = ~clk;

    int          nChecks = 0;
    int          nFail = 0;
    int          nCycle = 0;
    logic [31:0] expPc = RESET_PC;
    bit          pending = 1'b0;
    int          pendCnt = 0;
    logic [31:0] pendAddr = 32'h0;
    int          lat = 1;
    bit          lastReqFire = 1'b0;
    logic [31:0] reqLog [$];
    logic [31:0] consPc [$];
    logic [31:0] consData [$];
    int          consCyc [$];

    function automatic logic [31:0] memWord(input logic [31:0] a);
        case (a)
            32'h0: return SEQ_WORDS[0];
            32'h4: return SEQ_WORDS[1];
            32'h8: return SEQ_WORDS[2];
            32'hC: return SEQ_WORDS[3];
            default: return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
        endcase
    endfunction

    // Evaluates the handshakes of the coming edge at negedge, then drives the
    // memory response for the following cycle just after the edge.
    task automatic cycle();
        bit reqFire, consume;
        @(negedge clk);
        nCycle++;
        reqFire = imem_req_valid && imem_req_ready;
        consume = ir_valid && ir_ready;
        if (imem_rsp_valid) pending = 1'b0;
        if (!rst_n) begin
            expPc = RESET_PC;
            nChecks++;
            if (imem_req_valid !== 1'b0) begin
                nFail++;
                $display("FAIL reset_req_valid: got %b, required 0", imem_req_valid);
            end
        end else begin
            if (consume) begin
                nChecks++;
                if (ir_pc !== expPc || iReg !== memWord(expPc)) begin
                    nFail++;
                    $display("FAIL consume: ir_pc=%h iReg=%h, required ir_pc=%h iReg=%h",
                             ir_pc, iReg, expPc, memWord(expPc));
                end
                consCyc.push_back(nCycle);
                consPc.push_back(ir_pc);
                consData.push_back(iReg);
                expPc = expPc + 32'd4;
            end
            if (reqFire) begin
                nChecks++;
                if (imem_req_addr !== expPc || pending || (ir_valid && !ir_ready)) begin
                    nFail++;
                    $display("FAIL request: addr=%h outstanding=%0d irFull=%0d, required addr=%h outstanding=0 irFull=0",
                             imem_req_addr, pending, ir_valid && !ir_ready, expPc);
                end
                reqLog.push_back(imem_req_addr);
                pending  = 1'b1;
                pendCnt  = lat;
                pendAddr = imem_req_addr;
            end
            if (redirect_valid) expPc = redirect_pc & ~32'h3;
        end
        lastReqFire = reqFire;
        @(posedge clk);
        #1;
        if (pending) begin
            pendCnt--;
            imem_rsp_valid = (pendCnt == 0);
        end else begin
            imem_rsp_valid = 1'b0;
        end
        imem_rsp_data = imem_rsp_valid ? memWord(pendAddr) : $urandom;
    endtask

    task automatic clearLogs();
        reqLog.delete();
        consPc.delete();
        consData.delete();
        consCyc.delete();
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        ir_ready = 1'b0;
        imem_req_ready = 1'b0;
        pending = 1'b0;
        imem_rsp_valid = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        expPc = RESET_PC;
        clearLogs();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        nChecks++;
        if (imem_req_valid !== 1'b0 || ir_valid !== 1'b0 || iReg !== NOP_INSN ||
            ir_pc !== 32'h0 || imem_req_addr !== RESET_PC) begin
            nFail++;
            $display("FAIL reset_state: req_valid=%b ir_valid=%b iReg=%h ir_pc=%h addr=%h, required 0 0 %h 0 %h",
                     imem_req_valid, ir_valid, iReg, ir_pc, imem_req_addr, NOP_INSN, RESET_PC);
        end
        doReset();
        #1;
        nChecks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
            nFail++;
            $display("FAIL reset_release: req_valid=%b addr=%h, required 1 %h",
                     imem_req_valid, imem_req_addr, RESET_PC);
        end
    endtask

    task automatic test_sequence();
        doReset();
        imem_req_ready = 1'b1;
        ir_ready = 1'b1;
        lat = 1;
        for (int i = 0; i < 40 && consPc.size() < 4; i++) cycle();
        nChecks++;
        if (consPc.size() < 4) begin
            nFail++;
            $display("FAIL seq_count: got %0d instructions, required 4", consPc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                nChecks++;
                if (consPc[i] !== 32'(4 * i) || consData[i] !== SEQ_WORDS[i]) begin
                    nFail++;
                    $display("FAIL seq_insn%0d: ir_pc=%h iReg=%h, required %h %h",
                             i, consPc[i], consData[i], 32'(4 * i), SEQ_WORDS[i]);
                end
                if (i > 0) begin
                    nChecks++;
                    if (consCyc[i] - consCyc[i-1] != 2) begin
                        nFail++;
                        $display("FAIL seq_spacing%0d: got %0d cycles, required 2",
                                 i, consCyc[i] - consCyc[i-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_req_stall();
        int n4;
        doReset();
        imem_req_ready = 1'b1;
        ir_ready = 1'b1;
        lat = 1;
        cycle();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 10 && imem_req_valid !== 1'b1; i++) cycle();
        for (int k = 0; k < 3; k++) begin
            nChecks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin
                nFail++;
                $display("FAIL stall_addr%0d: valid=%b addr=%h, required 1 00000004",
                         k, imem_req_valid, imem_req_addr);
            end
            cycle();
        end
        imem_req_ready = 1'b1;
        for (int i = 0; i < 20 && consPc.size() < 2; i++) cycle();
        n4 = 0;
        foreach (reqLog[j]) if (reqLog[j] == 32'h4) n4++;
        nChecks++;
        if (n4 != 1 || consPc.size() < 2 || consPc[1] !== 32'h4) begin
            nFail++;
            $display("FAIL stall_result: requests to 4=%0d insns=%0d, required 1 request and ir_pc=4",
                     n4, consPc.size());
        end
    endtask

    task automatic test_ir_backpressure();
        doReset();
        imem_req_ready = 1'b1;
        ir_ready = 1'b0;
        lat = 1;
        for (int i = 0; i < 10; i++) cycle();
        nChecks++;
        if (reqLog.size() != 1 || ir_valid !== 1'b1 || ir_pc !== 32'h0 ||
            iReg !== SEQ_WORDS[0] || imem_req_valid !== 1'b0) begin
            nFail++;
            $display("FAIL backpressure_hold: reqs=%0d ir_valid=%b ir_pc=%h iReg=%h req_valid=%b, required 1 1 0 %h 0",
                     reqLog.size(), ir_valid, ir_pc, iReg, imem_req_valid, SEQ_WORDS[0]);
        end
        ir_ready = 1'b1;
        for (int i = 0; i < 10 && reqLog.size() < 2; i++) cycle();
        nChecks++;
        if (reqLog.size() < 2 || reqLog[1] !== 32'h4) begin
            nFail++;
            $display("FAIL backpressure_release: reqs=%0d, required second request to 00000004",
                     reqLog.size());
        end
    endtask

    task automatic test_redirect_wait();
        int iters;
        doReset();
        imem_req_ready = 1'b1;
        ir_ready = 1'b1;
        lat = 4;
        cycle();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        cycle();
        redirect_valid = 1'b0;
        lat = 1;
        iters = 0;
        for (int i = 0; i < 20 && reqLog.size() < 2; i++) begin
            nChecks++;
            if (ir_valid !== 1'b0) begin
                nFail++;
                $display("FAIL drain_ir_valid: got %b, required 0", ir_valid);
            end
            cycle();
            iters++;
        end
        nChecks++;
        if (reqLog.size() < 2 || reqLog[1] !== 32'h100 || iters != 4) begin
            nFail++;
            $display("FAIL drain_request: reqs=%0d cycles=%0d, required request to 00000100 after 4 cycles",
                     reqLog.size(), iters);
        end
        for (int i = 0; i < 10 && consPc.size() < 1; i++) cycle();
        nChecks++;
        if (consPc.size() < 1 || consPc[0] !== 32'h100) begin
            nFail++;
            $display("FAIL drain_insn: insns=%0d, required first ir_pc=00000100", consPc.size());
        end
    endtask

    task automatic test_redirect_rsp();
        doReset();
        imem_req_ready = 1'b1;
        ir_ready = 1'b1;
        lat = 1;
        cycle();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        cycle();
        redirect_valid = 1'b0;
        nChecks++;
        if (ir_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
            nFail++;
            $display("FAIL redirect_rsp: ir_valid=%b req_valid=%b addr=%h, required 0 1 00000200",
                     ir_valid, imem_req_valid, imem_req_addr);
        end
        for (int i = 0; i < 10 && consPc.size() < 1; i++) cycle();
        nChecks++;
        if (consPc.size() < 1 || consPc[0] !== 32'h200) begin
            nFail++;
            $display("FAIL redirect_rsp_insn: insns=%0d, required first ir_pc=00000200", consPc.size());
        end
    endtask

    task automatic test_reset_midwait();
        doReset();
        imem_req_ready = 1'b1;
        ir_ready = 1'b1;
        lat = 3;
        for (int i = 0; i < 40 && !(consPc.size() >= 2 && lastReqFire); i++) cycle();
        rst_n = 1'b0;
        #1;
        nChecks++;
        if (imem_req_valid !== 1'b0 || ir_valid !== 1'b0 || iReg !== NOP_INSN ||
            ir_pc !== 32'h0 || imem_req_addr !== RESET_PC) begin
            nFail++;
            $display("FAIL midwait_reset: req_valid=%b ir_valid=%b iReg=%h ir_pc=%h addr=%h, required 0 0 %h 0 %h",
                     imem_req_valid, ir_valid, iReg, ir_pc, imem_req_addr, NOP_INSN, RESET_PC);
        end
        for (int i = 0; i < 4; i++) cycle();
        clearLogs();
        rst_n = 1'b1;
        lat = 1;
        #1;
        nChecks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC || ir_valid !== 1'b0) begin
            nFail++;
            $display("FAIL midwait_release: req_valid=%b addr=%h ir_valid=%b, required 1 %h 0",
                     imem_req_valid, imem_req_addr, ir_valid, RESET_PC);
        end
        for (int i = 0; i < 10 && consPc.size() < 1; i++) cycle();
        nChecks++;
        if (consPc.size() < 1 || consPc[0] !== RESET_PC) begin
            nFail++;
            $display("FAIL midwait_insn: insns=%0d, required first ir_pc=%h", consPc.size(), RESET_PC);
        end
    endtask

    task automatic test_random();
        doReset();
        for (int i = 0; i < 3000; i++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            ir_ready = ($urandom_range(0, 9) < 7);
            lat = $urandom_range(1, 4);
            redirect_valid = ($urandom_range(0, 24) == 0);
            redirect_pc = $urandom;
            cycle();
        end
        redirect_valid = 1'b0;
        nChecks++;
        if (consPc.size() < 200) begin
            nFail++;
            $display("FAIL random_progress: got %0d instructions, required at least 200", consPc.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_sequence();
        test_req_stall();
        test_ir_backpressure();
        test_redirect_wait();
        test_redirect_rsp();
        test_reset_midwait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule : tb_scpu_fetch
`default_nettype wire
